// File: rtl/rx_memory_control.sv
// rx_memory_control
// Stages received segment payloads in a two-bank buffer, commits only complete,
// CRC-good, in-range, non-duplicate segments, and drains each committed segment
// into the R/G/B VRAM write ports (byte order R,B,G per pixel).
//
// Ports
//   clk125MHz, rst           : RX clock, synchronous active-high reset
//   rx_valid/rx_data         : payload byte stream
//   rx_sof                   : first payload byte (with rx_valid); samples seg/txid
//   rx_segment_num, rx_txid  : segment number and copy index of the frame
//   rx_eof, rx_crc_ok        : end-of-frame strobe and CRC verdict
//   vram_addr, vram_din      : pixel address and channel byte
//   vram_we_r/_g/_b          : per-channel write enables (one-hot or idle)
//   seg_done, seg_done_num   : segment fully written pulse and its number
//   drop_cnt, dup_cnt        : saturating discard counters
//   busy                     : frame filling, bank full or drain in progress
//
// Fill FSM
//   state     | meaning
//   F_IDLE    | waiting for rx_sof
//   F_FILL    | writing payload bytes into the claimed bank
//   F_DISCARD | no bank was free; ignoring bytes until rx_eof
// Drain FSM
//   state     | meaning
//   D_IDLE    | no bank being drained
//   D_READ    | reading one byte per cycle from the draining bank
//   D_TAIL    | waiting for the last byte to leave the output register

module rx_memory_control #(
    parameter int SEG_BYTES = 1080,
    parameter int NUM_SEGS  = 256,
    parameter int ADDR_W    = 24
) (
    input  logic              clk125MHz,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_sof,
    input  logic [7:0]        rx_segment_num,
    input  logic [7:0]        rx_txid,
    input  logic              rx_eof,
    input  logic              rx_crc_ok,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              vram_we_r,
    output logic              vram_we_g,
    output logic              vram_we_b,
    output logic              seg_done,
    output logic [7:0]        seg_done_num,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       dup_cnt,
    output logic              busy
);

    localparam int IDX_W = $clog2(SEG_BYTES + 1);
    localparam int PIX   = SEG_BYTES / 3;

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_DISCARD} fill_state_t;
    typedef enum logic [1:0] {D_IDLE, D_READ, D_TAIL} drain_state_t;
    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bank_state_t;

    fill_state_t  f_state, f_next;
    drain_state_t d_state, d_next;
    bank_state_t  bank_st [2];
    logic [7:0]   bank_seg [2];

    logic [7:0]   mem [2][SEG_BYTES];

    logic             f_bank;
    logic [7:0]       f_seg;
    logic [7:0]       f_txid;
    logic [IDX_W-1:0] wr_idx;
    logic             ovf;
    logic [7:0]       last_seg;
    logic             have_commit;
    logic             head;

    logic              dbank;
    logic [7:0]        dseg;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  rd_k;
    logic [1:0]        ch;
    logic [IDX_W-1:0]  pix;

    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [1:0]       rd_ch;
    logic [IDX_W-1:0] rd_pix;
    logic             rd_last;
    logic             wr_last;

    logic start, claim_ok, claim_bank, eof_eval, good, is_dup;
    logic commit, dup_hit, release_bank, drop_inc;
    logic mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic mem_bank;
    logic head_full, d_start, start_bank, drain_free;
    logic [7:0] start_seg;

    // ---------------- fill decision ----------------
    always_comb begin
        logic avail0, avail1;
        f_next       = f_state;
        // The bank being abandoned by a mid-frame rx_sof may be reclaimed at once.
        avail0       = (bank_st[0] == B_FREE) || (f_state == F_FILL && f_bank == 1'b0);
        avail1       = (bank_st[1] == B_FREE) || (f_state == F_FILL && f_bank == 1'b1);
        start        = rx_valid && rx_sof;
        claim_ok     = avail0 || avail1;
        claim_bank   = avail0 ? 1'b0 : 1'b1;
        eof_eval     = (f_state == F_FILL) && rx_eof;
        // txid 0 is not a valid copy index, so such a frame is treated as malformed.
        good         = rx_crc_ok && (wr_idx == IDX_W'(SEG_BYTES)) && !ovf &&
                       (32'(f_seg) < NUM_SEGS) && (f_txid != 8'd0);
        is_dup       = have_commit && (f_seg == last_seg);
        commit       = eof_eval && good && !is_dup;
        dup_hit      = eof_eval && good && is_dup;
        release_bank = (start && f_state == F_FILL) || (eof_eval && !commit);
        drop_inc     = (start && f_state == F_FILL) || (eof_eval && !good) ||
                       (start && !claim_ok);
        mem_we       = (start && claim_ok) ||
                       (f_state == F_FILL && rx_valid && !rx_sof &&
                        wr_idx < IDX_W'(SEG_BYTES));
        mem_addr     = start ? '0 : wr_idx;
        mem_bank     = start ? claim_bank : f_bank;

        if (start)
            f_next = claim_ok ? F_FILL : F_DISCARD;
        else if (rx_eof)
            f_next = F_IDLE;
    end

    // ---------------- drain decision ----------------
    always_comb begin
        d_next     = d_state;
        head_full  = (bank_st[head] == B_FULL);
        // A frame committing this cycle can start draining immediately.
        d_start    = (d_state == D_IDLE) && (head_full || commit);
        start_bank = head_full ? head : f_bank;
        start_seg  = head_full ? bank_seg[head] : f_seg;
        drain_free = (d_state == D_TAIL) && wr_last;

        case (d_state)
            D_IDLE: if (d_start) d_next = D_READ;
            D_READ: if (rd_k == IDX_W'(SEG_BYTES - 1)) d_next = D_TAIL;
            D_TAIL: if (wr_last) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // ---------------- staging memory ----------------
    always_ff @(posedge clk125MHz) begin
        if (mem_we)
            mem[mem_bank][mem_addr] <= rx_data;
        rd_data <= mem[dbank][rd_k];
    end

    // ---------------- state and datapath ----------------
    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            f_state      <= F_IDLE;
            d_state      <= D_IDLE;
            bank_st[0]   <= B_FREE;
            bank_st[1]   <= B_FREE;
            bank_seg[0]  <= '0;
            bank_seg[1]  <= '0;
            f_bank       <= 1'b0;
            f_seg        <= '0;
            f_txid       <= '0;
            wr_idx       <= '0;
            ovf          <= 1'b0;
            last_seg     <= '0;
            have_commit  <= 1'b0;
            head         <= 1'b0;
            dbank        <= 1'b0;
            dseg         <= '0;
            base         <= '0;
            rd_k         <= '0;
            ch           <= '0;
            pix          <= '0;
            rd_valid     <= 1'b0;
            rd_ch        <= '0;
            rd_pix       <= '0;
            rd_last      <= 1'b0;
            wr_last      <= 1'b0;
            vram_addr    <= '0;
            vram_din     <= '0;
            vram_we_r    <= 1'b0;
            vram_we_g    <= 1'b0;
            vram_we_b    <= 1'b0;
            seg_done     <= 1'b0;
            seg_done_num <= '0;
            drop_cnt     <= '0;
            dup_cnt      <= '0;
        end else begin
            f_state <= f_next;
            d_state <= d_next;

            if (start && claim_ok) begin
                f_bank <= claim_bank;
                f_seg  <= rx_segment_num;
                f_txid <= rx_txid;
                wr_idx <= IDX_W'(1);
                ovf    <= 1'b0;
            end else if (f_state == F_FILL && rx_valid) begin
                if (wr_idx < IDX_W'(SEG_BYTES))
                    wr_idx <= wr_idx + 1'b1;
                else
                    ovf <= 1'b1;
            end

            // Later assignments take priority: a reclaim beats the release.
            for (int i = 0; i < 2; i++) begin
                if (drain_free && dbank == 1'(i))
                    bank_st[i] <= B_FREE;
                if (release_bank && f_bank == 1'(i))
                    bank_st[i] <= B_FREE;
                if (commit && f_bank == 1'(i))
                    bank_st[i] <= B_FULL;
                if (start && claim_ok && claim_bank == 1'(i)) begin
                    bank_st[i]  <= B_FILLING;
                    bank_seg[i] <= rx_segment_num;
                end
            end

            // head tracks the oldest full bank so banks drain in commit order.
            if (drain_free)
                head <= ~dbank;
            if (commit) begin
                last_seg    <= f_seg;
                have_commit <= 1'b1;
                if (bank_st[~f_bank] != B_FULL)
                    head <= f_bank;
            end

            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (dup_hit && dup_cnt != 16'hFFFF)
                dup_cnt <= dup_cnt + 1'b1;

            if (d_start) begin
                dbank <= start_bank;
                dseg  <= start_seg;
                base  <= ADDR_W'(32'(start_seg) * 32'(PIX));
                rd_k  <= '0;
                ch    <= '0;
                pix   <= '0;
            end else if (d_state == D_READ) begin
                if (rd_k != IDX_W'(SEG_BYTES - 1))
                    rd_k <= rd_k + 1'b1;
                if (ch == 2'd2) begin
                    ch  <= '0;
                    pix <= pix + 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end

            rd_valid <= (d_state == D_READ);
            rd_ch    <= ch;
            rd_pix   <= pix;
            rd_last  <= (d_state == D_READ) && (rd_k == IDX_W'(SEG_BYTES - 1));

            // Channel order within a pixel on the wire is R, B, G.
            vram_we_r <= rd_valid && (rd_ch == 2'd0);
            vram_we_b <= rd_valid && (rd_ch == 2'd1);
            vram_we_g <= rd_valid && (rd_ch == 2'd2);
            if (rd_valid) begin
                vram_addr <= base + ADDR_W'(rd_pix);
                vram_din  <= rd_data;
            end
            wr_last <= rd_last;

            seg_done <= drain_free;
            if (drain_free)
                seg_done_num <= dseg;
        end
    end

    assign busy = (f_state == F_FILL) || (d_state != D_IDLE) ||
                  (bank_st[0] == B_FULL) || (bank_st[1] == B_FULL);

endmodule
